// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-stage bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic        ACC_WORD  = 1'b1;
  localparam logic        ACC_BYTE  = 1'b0;
  localparam logic [15:0] EVEN_MASK = 16'hFFFE;

  // Big-endian lane placement: a lone byte lands in the lane its address selects.
  function automatic logic [15:0] assemble_rd(input logic       word,
                                              input logic       odd,
                                              input logic [7:0] hi,
                                              input logic [7:0] lo);
    logic [15:0] r;
    if (word == ACC_BYTE) r = odd ? {8'h00, lo} : {lo, 8'h00};
    else                  r = {hi, lo};
    return r;
  endfunction

endpackage

// File: rtl/mem_phase_timer.sv
// Down-counter that measures one external strobe phase of WAIT_CYCLES cycles.
module mem_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic phase_end
);

  localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= LOAD;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - CW'(1);
    end
  end

  assign phase_end = active && (cnt == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// Serves 16-bit pipeline memory requests as one or two big-endian byte
// accesses on an 8-bit external memory.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for a request; latch it on arrival
//   HI      | MSB byte phase of a word access (even address)
//   LO      | LSB byte of a word, or the only byte of a byte access
//   DONE    | result valid for one cycle, requests ignored
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_addr_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic        mem_word_i,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  output logic        busy_o,
  output logic [15:0] ext_addr_o,
  output logic [7:0]  ext_data_o,
  input  logic [7:0]  ext_data_i,
  output logic        ext_re_o,
  output logic        ext_we_o
);

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        word_q;
  logic        write_q;
  logic [7:0]  hi_byte_q;
  logic        timer_start;
  logic        phase_end;
  logic        busy_c;
  logic        req;
  logic [15:0] eff_addr;

  assign req      = mem_re_i | mem_we_i;
  assign eff_addr = (mem_word_i == ACC_WORD) ? (mem_addr_i & EVEN_MASK) : mem_addr_i;

  mem_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (timer_start),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d     = state_q;
    busy_c      = 1'b0;
    timer_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          busy_c      = 1'b1;
          timer_start = 1'b1;
          state_d     = (mem_word_i == ACC_WORD) ? ST_HI : ST_LO;
        end
      end
      ST_HI: begin
        busy_c = 1'b1;
        if (phase_end) begin
          timer_start = 1'b1;
          state_d     = ST_LO;
        end
      end
      ST_LO: begin
        busy_c = 1'b1;
        if (phase_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = rst_n & busy_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= 1'b0;
      write_q    <= 1'b0;
      hi_byte_q  <= '0;
      mem_data_o <= '0;
      ext_addr_o <= '0;
      ext_data_o <= '0;
      ext_re_o   <= 1'b0;
      ext_we_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            // A simultaneous read and write is treated as a write.
            addr_q     <= eff_addr;
            wdata_q    <= mem_data_i;
            word_q     <= mem_word_i;
            write_q    <= mem_we_i;
            ext_addr_o <= eff_addr;
            ext_re_o   <= ~mem_we_i;
            ext_we_o   <= mem_we_i;
            if (mem_we_i)
              ext_data_o <= (mem_word_i == ACC_WORD) ? mem_data_i[15:8] : mem_data_i[7:0];
          end
        end
        ST_HI: begin
          if (phase_end) begin
            hi_byte_q  <= ext_data_i;
            ext_addr_o <= addr_q | 16'h0001;
            if (write_q) ext_data_o <= wdata_q[7:0];
          end
        end
        ST_LO: begin
          if (phase_end) begin
            ext_re_o <= 1'b0;
            ext_we_o <= 1'b0;
            if (!write_q)
              mem_data_o <= assemble_rd(word_q, addr_q[0], hi_byte_q, ext_data_i);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: two responders (WAIT_CYCLES 1 and 3) against a byte memory model.
module tb_mem_bus_responder;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        word_i = 1'b0;
  logic [15:0] wdata = '0;
  logic        re1 = 1'b0, we1 = 1'b0, re3 = 1'b0, we3 = 1'b0;

  logic [15:0] rd1, rd3, ext_addr1, ext_addr3;
  logic [7:0]  ext_do1, ext_do3, ext_di1, ext_di3;
  logic        busy1, busy3, ext_re1, ext_re3, ext_we1, ext_we3;

  int          n_vec = 0;
  int          n_err = 0;
  beat_t       q1[$];
  beat_t       q3[$];
  beat_t       mb1, mb3;
  logic [15:0] last_rd1 = '0, last_rd3 = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h1234: mem_rd = 8'hAB;
      16'h1235: mem_rd = 8'hCD;
      default:  mem_rd = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign ext_di1 = mem_rd(ext_addr1);
  assign ext_di3 = mem_rd(ext_addr3);

  mem_bus_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr_i(addr), .mem_re_i(re1), .mem_we_i(we1),
    .mem_word_i(word_i), .mem_data_i(wdata), .mem_data_o(rd1), .busy_o(busy1),
    .ext_addr_o(ext_addr1), .ext_data_o(ext_do1), .ext_data_i(ext_di1),
    .ext_re_o(ext_re1), .ext_we_o(ext_we1)
  );

  mem_bus_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_addr_i(addr), .mem_re_i(re3), .mem_we_i(we3),
    .mem_word_i(word_i), .mem_data_i(wdata), .mem_data_o(rd3), .busy_o(busy3),
    .ext_addr_o(ext_addr3), .ext_data_o(ext_do3), .ext_data_i(ext_di3),
    .ext_re_o(ext_re3), .ext_we_o(ext_we3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Every strobed cycle must match the next expected beat.
  always @(negedge clk) begin
    if (ext_re1 || ext_we1) begin
      if (q1.size() == 0) chk("beat1_extra", {30'd0, ext_we1, ext_re1}, 32'd0);
      else begin
        mb1 = q1.pop_front();
        chk("beat1", {6'd0, ext_we1, ext_re1, ext_addr1, ext_we1 ? ext_do1 : 8'h00},
            {6'd0, mb1.we, ~mb1.we, mb1.addr, mb1.data});
      end
    end
  end

  always @(negedge clk) begin
    if (ext_re3 || ext_we3) begin
      if (q3.size() == 0) chk("beat3_extra", {30'd0, ext_we3, ext_re3}, 32'd0);
      else begin
        mb3 = q3.pop_front();
        chk("beat3", {6'd0, ext_we3, ext_re3, ext_addr3, ext_we3 ? ext_do3 : 8'h00},
            {6'd0, mb3.we, ~mb3.we, mb3.addr, mb3.data});
      end
    end
  end

  // Drives one request (left asserted) and returns at the DONE cycle.
  task automatic do_req(input int d, input logic [15:0] a, input logic re, input logic we,
                        input logic word, input logic [15:0] wd);
    int          nb, busy_n, waitc;
    logic [15:0] ea, exp_rd;
    beat_t       b;
    waitc = (d == 1) ? 1 : 3;
    ea    = word ? (a & 16'hFFFE) : a;
    nb    = word ? 2 : 1;
    @(posedge clk); #1;
    addr = a; word_i = word; wdata = wd;
    if (d == 1) begin re1 = re; we1 = we; end
    else        begin re3 = re; we3 = we; end
    for (int p = 0; p < nb; p++) begin
      b.we   = we;
      b.addr = (p == 1) ? (ea | 16'h0001) : ea;
      b.data = !we ? 8'h00 : (word && p == 0) ? wd[15:8] : wd[7:0];
      repeat (waitc) begin
        if (d == 1) q1.push_back(b);
        else        q3.push_back(b);
      end
    end
    if (!we) begin
      if (word)      exp_rd = {mem_rd(ea), mem_rd(ea | 16'h0001)};
      else if (a[0]) exp_rd = {8'h00, mem_rd(a)};
      else           exp_rd = {mem_rd(a), 8'h00};
      if (d == 1) last_rd1 = exp_rd;
      else        last_rd3 = exp_rd;
    end
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((d == 1) ? busy1 : busy3) busy_n++;
      else break;
    end
    chk("busy_cycles", busy_n, 1 + waitc * nb);
    if (d == 1) chk("rd_data1", {16'd0, rd1}, {16'd0, last_rd1});
    else        chk("rd_data3", {16'd0, rd3}, {16'd0, last_rd3});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    re1 = 1'b0; we1 = 1'b0; re3 = 1'b0; we3 = 1'b0;
  endtask

  initial begin
    beat_t b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_strobes1", {30'd0, ext_re1, ext_we1}, 32'd0);
    chk("rst_ext_addr1", {16'd0, ext_addr1}, 32'd0);
    chk("rst_ext_data1", {24'd0, ext_do1}, 32'd0);
    chk("rst_rd1", {16'd0, rd1}, 32'd0);
    chk("rst_rd3", {16'd0, rd3}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_req(1, 16'h1235, 1'b1, 1'b0, 1'b1, 16'h0000); idle();
    do_req(1, 16'h1235, 1'b1, 1'b0, 1'b0, 16'h0000); idle();
    do_req(1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000); idle();
    do_req(1, 16'h0040, 1'b0, 1'b1, 1'b1, 16'hBEEF); idle();
    do_req(1, 16'h0041, 1'b0, 1'b1, 1'b0, 16'h12F0); idle();
    do_req(1, 16'h0100, 1'b1, 1'b1, 1'b1, 16'h5566); idle();
    do_req(1, 16'h1235, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_req(1, 16'h1235, 1'b1, 1'b0, 1'b0, 16'h0000); idle();
    for (int i = 0; i < 4; i++) begin
      do_req(1, 16'($urandom), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'h0000); idle();
    end

    do_req(3, 16'h1235, 1'b1, 1'b0, 1'b1, 16'h0000); idle();
    do_req(3, 16'h0040, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    do_req(3, 16'h0040, 1'b0, 1'b1, 1'b1, 16'hBEEF); idle();
    do_req(3, 16'h0777, 1'b1, 1'b0, 1'b0, 16'h0000); idle();

    // Reset during the HI phase of a word read.
    @(posedge clk); #1;
    addr = 16'h1235; word_i = 1'b1; re1 = 1'b1;
    b.we = 1'b0; b.addr = 16'h1234; b.data = 8'h00;
    q1.push_back(b);
    @(negedge clk);
    chk("mid_busy_idle", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    chk("mid_hi_strobe", {31'd0, ext_re1}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_busy_in_rst", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1 re1 = 1'b0;
    @(negedge clk);
    chk("mid_strobes", {30'd0, ext_re1, ext_we1}, 32'd0);
    chk("mid_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rd1", {16'd0, rd1}, 32'd0);
    chk("mid_rd3", {16'd0, rd3}, 32'd0);
    last_rd1 = '0; last_rd3 = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("post_rst_idle", {31'd0, busy1}, 32'd0);
    do_req(1, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000); idle();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("q1_left", q1.size(), 32'd0);
    chk("q3_left", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
